// File: rtl/mod_pkg.sv
// Shared constants for the multi-channel modulator front end.
// Holds the LFSR tap positions, bipolar sample codes and the per-channel seed rule.
package mod_pkg;

  localparam logic [1:0] SMP_POS  = 2'b01;
  localparam logic [1:0] SMP_NEG  = 2'b11;
  localparam logic [1:0] SMP_ZERO = 2'b00;

  localparam int TAP_HI_7  = 6;
  localparam int TAP_LO_7  = 5;
  localparam int TAP_HI_9  = 8;
  localparam int TAP_LO_9  = 4;
  localparam int TAP_HI_15 = 14;
  localparam int TAP_LO_15 = 13;

  typedef enum logic {
    MODE_PRBS = 1'b0,
    MODE_ALT  = 1'b1
  } tx_mode_e;

  function automatic int prbs_tap_hi(input int order);
    case (order)
      7:       return TAP_HI_7;
      15:      return TAP_HI_15;
      default: return TAP_HI_9;
    endcase
  endfunction

  function automatic int prbs_tap_lo(input int order);
    case (order)
      7:       return TAP_LO_7;
      15:      return TAP_LO_15;
      default: return TAP_LO_9;
    endcase
  endfunction

  // All-ones seed XOR channel index; with at most 8 channels it is never zero.
  function automatic logic [15:0] prbs_seed(input int order, input int k);
    return ((16'd1 << order) - 16'd1) ^ 16'(k);
  endfunction

endpackage

// File: rtl/mod_tx_core_prbs_lfsr.sv
// Fibonacci PRBS source for one channel.
// Advances only on i_adv and flags when its next state returns to the seed.
module prbs_lfsr
  import mod_pkg::*;
#(
  parameter int               ORDER = 9,
  parameter logic [ORDER-1:0] SEED  = '1
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_adv,
  output logic o_bit,
  output logic o_next_is_seed
);

  localparam int TAP_HI = prbs_tap_hi(ORDER);
  localparam int TAP_LO = prbs_tap_lo(ORDER);

  logic [ORDER-1:0] lfsr;
  logic [ORDER-1:0] lfsr_next;

  always_comb begin
    lfsr_next = {lfsr[ORDER-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      lfsr <= SEED;
    end else if (i_clear) begin
      lfsr <= SEED;
    end else if (i_adv) begin
      lfsr <= lfsr_next;
    end
  end

  assign o_bit          = lfsr[ORDER-1];
  assign o_next_is_seed = (lfsr_next == SEED);

endmodule

// File: rtl/mod_tx_core.sv
// Multi-channel modulator front end: symbol strobe generator plus N PRBS sources,
// producing zero-stuffed oversampled bipolar samples for the pulse-shaping FIR.
module mod_tx_core
  import mod_pkg::*;
#(
  parameter int NB_COUNT   = 3,
  parameter int N_CH       = 2,
  parameter int PRBS_ORDER = 9
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic [NB_COUNT-1:0] i_os_period,
  input  logic [N_CH-1:0]     i_ch_en,
  input  logic                i_mode,
  output logic                o_valid,
  output logic [2*N_CH-1:0]   o_sample,
  output logic                o_wrap
);

  if (!(PRBS_ORDER == 7 || PRBS_ORDER == 9 || PRBS_ORDER == 15)) begin : g_bad_order
    $error("mod_tx_core: PRBS_ORDER must be 7, 9 or 15");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("mod_tx_core: N_CH must be in 1..8");
  end

  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] period_sh;
  logic                tick;
  logic                alt_mode;
  logic [N_CH-1:0]     toggle;
  logic [N_CH-1:0]     lfsr_bit;
  logic [N_CH-1:0]     next_seed;
  logic [N_CH-1:0]     adv;
  logic [N_CH-1:0]     data_bit;
  logic [2*N_CH-1:0]   sample_next;
  logic                wrap_next;

  assign alt_mode = (i_mode == MODE_ALT);
  assign tick     = i_enable && (count == period_sh) && !i_clear;

  // The shadow period is only reloaded at a wrap or while idle, so a mid-run
  // change never shortens the symbol already in flight.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count     <= '0;
      period_sh <= '1;
    end else if (i_clear) begin
      count     <= '0;
      period_sh <= i_os_period;
    end else if (i_enable) begin
      if (count == period_sh) begin
        count     <= '0;
        period_sh <= i_os_period;
      end else begin
        count <= count + NB_COUNT'(1);
      end
    end else begin
      period_sh <= i_os_period;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      toggle <= '0;
    end else if (i_clear) begin
      toggle <= '0;
    end else if (tick && alt_mode) begin
      toggle <= toggle ^ i_ch_en;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign adv[k] = tick && i_ch_en[k] && !alt_mode;

    prbs_lfsr #(
      .ORDER (PRBS_ORDER),
      .SEED  (PRBS_ORDER'(prbs_seed(PRBS_ORDER, k)))
    ) u_lfsr (
      .clock          (clock),
      .i_reset        (i_reset),
      .i_clear        (i_clear),
      .i_adv          (adv[k]),
      .o_bit          (lfsr_bit[k]),
      .o_next_is_seed (next_seed[k])
    );
  end

  assign data_bit = alt_mode ? toggle : lfsr_bit;

  always_comb begin
    sample_next = {N_CH{SMP_ZERO}};
    for (int k = 0; k < N_CH; k++) begin
      if (tick && i_ch_en[k]) begin
        sample_next[2*k +: 2] = data_bit[k] ? SMP_NEG : SMP_POS;
      end
    end
    wrap_next = tick && i_ch_en[0] && !alt_mode && next_seed[0];
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid  <= 1'b0;
      o_sample <= '0;
      o_wrap   <= 1'b0;
    end else if (i_clear) begin
      o_valid  <= 1'b0;
      o_sample <= '0;
      o_wrap   <= 1'b0;
    end else begin
      o_valid  <= tick;
      o_sample <= sample_next;
      o_wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mod_tx_core.sv
// Self-checking bench for mod_tx_core (NB_COUNT=3, N_CH=2, PRBS_ORDER=9).
// Expected samples are queued when ticks are scheduled and popped by a negedge monitor.
module tb_mod_tx_core;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic       i_clear;
  logic [2:0] i_os_period;
  logic [1:0] i_ch_en;
  logic       i_mode;
  logic       o_valid;
  logic [3:0] o_sample;
  logic       o_wrap;

  typedef struct packed {
    logic [3:0] sample;
    logic       wrap;
  } exp_t;

  exp_t       sb[$];
  int         gap_log[$];
  int         wrap_log[$];
  logic [3:0] sample_log[$];
  logic [8:0] m_lfsr [2];
  logic [1:0] m_tog;
  int         checks    = 0;
  int         errors    = 0;
  int         valid_cnt = 0;
  int         cyc       = 0;
  int         last_vcyc = 0;
  int         base;

  mod_tx_core #(
    .NB_COUNT   (3),
    .N_CH       (2),
    .PRBS_ORDER (9)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_clear     (i_clear),
    .i_os_period (i_os_period),
    .i_ch_en     (i_ch_en),
    .i_mode      (i_mode),
    .o_valid     (o_valid),
    .o_sample    (o_sample),
    .o_wrap      (o_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clock);
    #1;
  endtask

  task automatic resetModel();
    m_lfsr[0] = 9'h1FF;
    m_lfsr[1] = 9'h1FE;
    m_tog     = 2'b00;
  endtask

  // Reference PRBS9 (x^9 + x^5 + 1) and alternating-pattern model, one entry per tick.
  task automatic pushExpected(input int n, input logic [1:0] en, input logic mode);
    exp_t       e;
    logic       b;
    logic [8:0] nxt;
    for (int i = 0; i < n; i++) begin
      e.sample = 4'b0000;
      e.wrap   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (en[k]) begin
          b = mode ? m_tog[k] : m_lfsr[k][8];
          e.sample[2*k +: 2] = b ? 2'b11 : 2'b01;
          if (mode) begin
            m_tog[k] = ~m_tog[k];
          end else begin
            nxt = {m_lfsr[k][7:0], m_lfsr[k][8] ^ m_lfsr[k][4]};
            if (k == 0 && nxt == 9'h1FF) e.wrap = 1'b1;
            m_lfsr[k] = nxt;
          end
        end
      end
      sb.push_back(e);
    end
  endtask

  // With a zero period every enabled edge is a tick, so n enabled edges give n symbols.
  task automatic applyStimulus(input int n, input logic [1:0] en, input logic mode);
    pushExpected(n, en, mode);
    i_ch_en  = en;
    i_mode   = mode;
    i_enable = 1'b1;
    repeat (n) stepClk();
    i_enable = 1'b0;
    repeat (2) stepClk();
  endtask

  task automatic waitValids(input int target, input int budget);
    int t;
    t = 0;
    while (valid_cnt < target && t < budget) begin
      stepClk();
      t++;
    end
    checkOutput("wait_valids", valid_cnt, target);
  endtask

  task automatic doClear(input logic [2:0] os);
    i_os_period = os;
    i_enable    = 1'b0;
    i_clear     = 1'b1;
    stepClk();
    i_clear = 1'b0;
    resetModel();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (i_reset && o_valid) begin
      gap_log.push_back(cyc - last_vcyc);
      last_vcyc = cyc;
      sample_log.push_back(o_sample);
      if (o_wrap) wrap_log.push_back(valid_cnt);
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sample", o_sample, e.sample);
        checkOutput("wrap", o_wrap, e.wrap);
      end
      valid_cnt++;
    end else if (i_reset) begin
      checkOutput("stuff_sample", o_sample, 4'b0000);
      checkOutput("stuff_wrap", o_wrap, 1'b0);
    end
  end

  initial begin
    i_reset     = 1'b0;
    i_enable    = 1'b0;
    i_clear     = 1'b0;
    i_os_period = 3'b111;
    i_ch_en     = 2'b11;
    i_mode      = 1'b0;
    repeat (3) stepClk();
    checkOutput("rst_valid", o_valid, 1'b0);
    checkOutput("rst_sample", o_sample, 4'b0000);
    checkOutput("rst_wrap", o_wrap, 1'b0);

    // Reset defaults: 8-clock cadence, ch0 starts with nine -1 symbols.
    resetModel();
    pushExpected(10, 2'b11, 1'b0);
    i_reset  = 1'b1;
    i_enable = 1'b1;
    waitValids(10, 200);
    for (int i = 1; i < 10; i++) checkOutput("p1_gap", gap_log[i], 8);
    for (int i = 0; i < 9; i++) checkOutput("p1_ch0_neg", {30'd0, sample_log[i][1:0]}, 2'b11);
    checkOutput("p1_ch0_10th", {30'd0, sample_log[9][1:0]}, 2'b01);

    // Mid-symbol period change finishes the current symbol first.
    i_os_period = 3'd2;
    pushExpected(5, 2'b11, 1'b0);
    waitValids(15, 200);
    checkOutput("p2_gap_keep", gap_log[10], 8);
    for (int i = 11; i < 15; i++) checkOutput("p2_gap_new", gap_log[i], 3);

    // Full PRBS period with one tick per clock.
    doClear(3'd0);
    base = valid_cnt;
    applyStimulus(1030, 2'b11, 1'b0);
    checkOutput("p3_valids", valid_cnt, base + 1030);
    checkOutput("p3_wrap_count", wrap_log.size(), 2);
    if (wrap_log.size() >= 2) begin
      checkOutput("p3_first_wrap", wrap_log[0] - base + 1, 511);
      checkOutput("p3_wrap_period", wrap_log[1] - wrap_log[0], 511);
    end

    // Channel enables and alternating test mode; ch0 resumes without skipping.
    base = valid_cnt;
    applyStimulus(6, 2'b10, 1'b1);
    for (int i = 0; i < 6; i++)
      checkOutput("p4_alt", sample_log[base + i], (i % 2) ? 4'b1100 : 4'b0100);
    applyStimulus(4, 2'b11, 1'b0);
    applyStimulus(2, 2'b11, 1'b1);

    // Freeze slips the strobe by the idle clocks; clear on a tick restarts everything.
    doClear(3'd7);
    base = valid_cnt;
    i_ch_en  = 2'b11;
    i_mode   = 1'b0;
    pushExpected(3, 2'b11, 1'b0);
    i_enable = 1'b1;
    waitValids(base + 1, 100);
    i_enable = 1'b0;
    repeat (5) stepClk();
    i_enable = 1'b1;
    waitValids(base + 3, 100);
    checkOutput("p5_gap_frozen", gap_log[base + 1], 13);
    checkOutput("p5_gap_normal", gap_log[base + 2], 8);
    repeat (6) stepClk();
    i_clear = 1'b1;
    stepClk();
    i_clear = 1'b0;
    resetModel();
    pushExpected(1, 2'b11, 1'b0);
    waitValids(base + 4, 100);
    checkOutput("p5_gap_after_clear", gap_log[base + 3], 16);
    checkOutput("p5_reseed_ch0", {30'd0, sample_log[base + 3][1:0]}, 2'b11);
    checkOutput("sb_drain", sb.size(), 0);

    // Asynchronous reset between edges while a strobe is high.
    begin
      int t;
      t = 0;
      while (!o_valid && t < 40) begin
        stepClk();
        t++;
      end
    end
    checkOutput("p6_valid_seen", o_valid, 1'b1);
    checkOutput("p6_sample_active", (o_sample != 4'b0000), 1'b1);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("p6_async_valid", o_valid, 1'b0);
    checkOutput("p6_async_sample", o_sample, 4'b0000);
    checkOutput("p6_async_wrap", o_wrap, 1'b0);
    repeat (2) stepClk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_tx_core.md
Name: mod_tx_core

Overview:
- Parametrised, multi-channel successor to the modulator front end. It combines the symbol-rate strobe generator and N independent PRBS symbol sources.
- Emits zero-stuffed, oversampled bipolar samples per channel, ready for the FIR pulse-shaping stage.
- Adds over the previous generation:
  - runtime-selectable oversampling period;
  - selectable PRBS order;
  - per-channel enable;
  - alternating-pattern test mode;
  - synchronous restart;
  - PRBS period-wrap marker.

Parameters:
- NB_COUNT, 3: width of the oversampling counter; maximum period is 2^NB_COUNT clocks.
- N_CH, 2: number of symbol channels, range 1..8.
- PRBS_ORDER, 9: LFSR order; legal values 7, 9, 15.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  global run; low freezes the counter and blocks ticks.
- i_clear  in  1  synchronous restart; highest priority after reset.
- i_os_period  in  NB_COUNT  oversampling period minus 1; samples per symbol = i_os_period+1.
- i_ch_en  in  N_CH  per-channel enable.
- i_mode  in  1  0 = PRBS data, 1 = alternating 0/1 test pattern.
- o_valid  out  1  one-cycle symbol strobe.
- o_sample  out  2*N_CH  per-channel 2-bit two's-complement sample; channel k occupies bits [2k+1:2k].
- o_wrap  out  1  one-cycle pulse when channel 0's LFSR returns to its seed.

Behaviour:
- Reset (async, i_reset=0) sets:
  - count=0;
  - period_sh = all ones (legacy 2^NB_COUNT cadence);
  - lfsr[k] = seed_k;
  - toggle[k]=0;
  - o_valid=0, o_sample=0, o_wrap=0.
- seed_k = {PRBS_ORDER{1'b1}} XOR k. Since N_CH<=8, no seed is zero.
- i_clear=1 (synchronous) has the same effect as reset, except period_sh <= i_os_period.
- Counter, when i_enable=1:
  - if count==period_sh: count<=0 and period_sh<=i_os_period;
  - otherwise count<=count+1.
- Counter, when i_enable=0: count holds and period_sh<=i_os_period.
- Period changes mid-run take effect only at the wrap, so no short or runt symbol is produced.
- tick = i_enable && count==period_sh && !i_clear.
- On a tick edge:
  - o_valid<=1.
  - For each channel k with i_ch_en[k]=1:
    - the data bit b is lfsr[k][ORDER-1] when mode=0, or toggle[k] when mode=1;
    - o_sample[k] <= (b ? 2'b11 : 2'b01), i.e. bit 0 maps to +1 and bit 1 maps to -1;
    - in mode 0 the LFSR advances; in mode 1 toggle[k] flips and the LFSR holds.
  - Disabled channels output 2'b00 and hold all state.
- On a non-tick edge: o_valid<=0 and all o_sample<=0 (zero stuffing).
- Latency: the tick is registered, so the output appears 1 clock after count==period_sh.
- LFSR (Fibonacci) step: lfsr <= {lfsr[ORDER-2:0], fb}, where fb is:
  - ORDER 7: l[6]^l[5];
  - ORDER 9: l[8]^l[4];
  - ORDER 15: l[14]^l[13].
- o_wrap<=1 on a tick where ch0 is enabled, mode=0, and ch0's next LFSR state == seed_0. Otherwise o_wrap=0. The period is 2^ORDER-1 ticks.
- Simultaneous events:
  - i_clear overrides a tick.
  - A change of i_mode mid-stream does not reseed anything.
  - Dropping i_enable mid-symbol freezes count; on resume the symbol completes with the remaining count.
- Async reset mid-symbol clears all outputs immediately, without waiting for a clock edge.
- Illegal PRBS_ORDER values are rejected by an elaboration-time check.

Decomposition:
- Shared package mod_pkg holds:
  - tap-position constants per order;
  - the sample encodings (POS=2'b01, NEG=2'b11, ZERO=2'b00);
  - the seed function.
- One sub-module, prbs_lfsr: parametrised by ORDER and SEED, with ports clock, i_reset, i_clear, i_adv, o_bit, o_next_is_seed. It is instantiated N_CH times via generate.

Test Plan:
- Reset defaults: reset, then i_enable=1, i_os_period held at 3'b111, all channels enabled, mode=0. Required: o_valid period is exactly 8 clocks. The first 9 ch0 samples with ORDER=9 are 2'b11, and the 10th is 2'b01.
- Runtime period change: set i_os_period=3'd2 mid-symbol. Required: the current symbol keeps its 8-clock spacing, then o_valid spacing becomes 3 clocks. o_sample is nonzero only on o_valid cycles.
- Full PRBS period: mode=0, i_os_period=0, ORDER=9. Required: o_wrap pulses after exactly 511 ticks and repeats every 511. Ch1 sequence matches a reference model seeded with 9'h1FE.
- Per-channel enable and test mode: i_ch_en=2'b10, mode=1. Required: ch0 output is always 2'b00; ch1 output alternates 01, 11, 01, ... on each tick. Toggling ch0 enable later resumes its sequence without skipping symbols.
- Freeze and clear: drop i_enable for 5 clocks mid-symbol and check the strobe slips by exactly 5. Then assert i_clear on a tick cycle: required no o_valid that cycle, count=0, and the LFSRs are reseeded, so the next ch0 sample is again 2'b11.
- Asynchronous reset: assert i_reset=0 between clock edges while o_valid=1. Required: o_valid, o_sample and o_wrap go to 0 immediately, without waiting for a clock edge.
